// File: rtl/button_event_arbiter_pkg.sv
// Shared types and defaults for the button event arbiter.
package button_pkg;

  localparam int unsigned BTN_N_BTN_DEFAULT = 4;

  typedef enum logic [1:0] {
    BTN_ARB_IDLE    = 2'd0,
    BTN_ARB_OFFER   = 2'd1,
    BTN_ARB_LOCKOUT = 2'd2
  } btn_arb_state_t;

endpackage

// File: rtl/button_event_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module button_rr_pick
  import button_pkg::*;
#(
  parameter  int unsigned N_BTN = BTN_N_BTN_DEFAULT,
  localparam int unsigned IDX_W = $clog2(N_BTN)
) (
  input  logic [N_BTN-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  int unsigned j;

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      j = (int'(ptr) + i) % N_BTN;
      if (!any && req[IDX_W'(j)]) begin
        any     = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Latches button press pulses and serialises them round-robin onto a valid/ready port.
// Define BTN_ARB_OVERFLOW_EN to add sticky per-channel lost-press flags (ovf_clr/overflow).
module button_event_arbiter
  import button_pkg::*;
#(
  parameter  int unsigned N_BTN   = BTN_N_BTN_DEFAULT,
  parameter  int unsigned LOCKOUT = 0,
  localparam int unsigned IDX_W   = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] pulse_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_idx,
  output logic [N_BTN-1:0] pending
`ifdef BTN_ARB_OVERFLOW_EN
  ,
  input  logic             ovf_clr,
  output logic [N_BTN-1:0] overflow
`endif
);

  localparam int unsigned CNT_W = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;

  btn_arb_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic             any;
  logic             accept;
  logic [N_BTN-1:0] clr;

  button_rr_pick #(.N_BTN(N_BTN)) u_pick (
    .req     (pending),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign accept = evt_valid & evt_ready;

  always_comb begin
    clr = '0;
    if (accept) clr[evt_idx] = 1'b1;
  end

  // A fresh pulse in the clearing cycle survives the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= (pending & ~clr) | pulse_in;
  end

`ifdef BTN_ARB_OVERFLOW_EN
  logic [N_BTN-1:0] ovf_set;
  assign ovf_set = pulse_in & pending & ~clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       overflow <= '0;
    else if (ovf_clr) overflow <= ovf_set;
    else              overflow <= overflow | ovf_set;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= BTN_ARB_IDLE;
      evt_valid <= 1'b0;
      evt_idx   <= '0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        BTN_ARB_IDLE: begin
          if (any) begin
            evt_idx   <= gnt_idx;
            evt_valid <= 1'b1;
            state     <= BTN_ARB_OFFER;
          end
        end
        BTN_ARB_OFFER: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            if (evt_idx == IDX_W'(N_BTN - 1)) ptr <= '0;
            else                              ptr <= evt_idx + 1'b1;
            if (LOCKOUT == 0) begin
              state <= BTN_ARB_IDLE;
            end else begin
              cnt   <= CNT_W'(LOCKOUT - 1);
              state <= BTN_ARB_LOCKOUT;
            end
          end
        end
        BTN_ARB_LOCKOUT: begin
          evt_valid <= 1'b0;
          if (cnt == '0) state <= BTN_ARB_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: begin
          state     <= BTN_ARB_IDLE;
          evt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
